harris_response: RTL and testbench

HARRIS_RESPONSE -- requirements
Module: harris_response

---
 rtl/harris_response.sv | 251 +++++++++++++++++++++++++
 tb/tb_harris_response.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harris_response.sv
`timescale 1ns/1ps
// harris_response
// Harris corner response over a 6x6 pixel window, one window per clock.
// The window is captured into an input register. Five compute stages follow:
//   S1 Sobel gradients at the 16 interior centres
//   S2 per-centre products Gx^2, Gy^2 and Gx*Gy
//   S3 sums of the products over the 16 centres
//   S4 det and squared trace
//   S5 response, corner flag, coordinates and the per-frame corner count
// A window sampled at edge N shows up on out_valid after edge N+5.
// All arithmetic is exact at every stage.
module harris_response #(
  parameter int                 IMG_W  = 512,
  parameter int                 IMG_H  = 512,
  parameter logic signed [51:0] THRESH = 52'sd1_000_000_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [287:0]        window_flat,
  input  logic                window_valid,
  output logic signed [51:0]  resp,
  output logic                corner,
  output logic                out_valid,
  output logic [8:0]          out_x,
  output logic [8:0]          out_y,
  output logic [31:0]         corner_count,
  output logic                frame_done
);

  localparam int         PW      = 8;
  localparam int         NC      = 16;
  localparam logic [8:0] X_LAST  = 9'(IMG_W - 32'sd1);
  localparam logic [8:0] Y_LAST  = 9'(IMG_H - 32'sd1);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Pixel (r, c) of a window, zero-extended into the 11-bit signed gradient domain.
  function automatic logic signed [10:0] pix(input logic [287:0] win, input int r, input int c);
    logic [8:0] base;
    base = 9'((r * 32'sd6 + c) * PW);
    return $signed({3'b000, win[base +: PW]});
  endfunction

  // Horizontal Sobel at centre (r, c) with row weights 1,2,1.
  function automatic logic signed [10:0] sobel_gx(input logic [287:0] win, input int r, input int c);
    return (pix(win, r - 32'sd1, c + 32'sd1) - pix(win, r - 32'sd1, c - 32'sd1))
         + ((pix(win, r, c + 32'sd1) - pix(win, r, c - 32'sd1)) * 11'sd2)
         + (pix(win, r + 32'sd1, c + 32'sd1) - pix(win, r + 32'sd1, c - 32'sd1));
  endfunction

  // Vertical Sobel at centre (r, c) with column weights 1,2,1.
  function automatic logic signed [10:0] sobel_gy(input logic [287:0] win, input int r, input int c);
    return (pix(win, r + 32'sd1, c - 32'sd1) - pix(win, r - 32'sd1, c - 32'sd1))
         + ((pix(win, r + 32'sd1, c) - pix(win, r - 32'sd1, c)) * 11'sd2)
         + (pix(win, r + 32'sd1, c + 32'sd1) - pix(win, r - 32'sd1, c + 32'sd1));
  endfunction

  // Magnitude of a gradient. Sobel output is bounded by +/-1020, so 10 bits suffice.
  function automatic logic [9:0] mag11(input logic signed [10:0] a);
    logic [9:0] m;
    if (a[10]) begin
      m = 10'(-a);
    end else begin
      m = 10'(a);
    end
    return m;
  endfunction

  // Square of a gradient, computed on the magnitude so the result is naturally unsigned.
  function automatic logic [19:0] sq11(input logic signed [10:0] a);
    logic [9:0] m;
    m = mag11(a);
    return {10'd0, m} * {10'd0, m};
  endfunction

  // Signed product of two gradients, computed as sign and magnitude.
  function automatic logic signed [20:0] mul11(input logic signed [10:0] a, input logic signed [10:0] b);
    logic [19:0] p;
    logic [20:0] res;
    p = {10'd0, mag11(a)} * {10'd0, mag11(b)};
    if (a[10] ^ b[10]) begin
      res = -{1'b0, p};
    end else begin
      res = {1'b0, p};
    end
    return $signed(res);
  endfunction

  // Pipeline valid bits: input register, then stages S1 to S4. S5 drives out_valid.
  logic               r_v0, r_v1, r_v2, r_v3, r_v4;
  logic [287:0]       r_win;
  logic signed [10:0] r_gx  [NC];
  logic signed [10:0] r_gy  [NC];
  logic [19:0]        r_gxx [NC];
  logic [19:0]        r_gyy [NC];
  logic signed [20:0] r_gxy [NC];
  logic [23:0]        r_sxx, r_syy;
  logic signed [24:0] r_sxy;
  logic signed [51:0] r_det;
  logic [51:0]        r_tr2;

  logic [23:0]        w_sxx, w_syy;
  logic signed [24:0] w_sxy;
  logic [23:0]        w_sxy_mag;
  logic [24:0]        w_tr_sum;
  logic [51:0]        w_det, w_tr2;
  logic signed [51:0] w_resp;
  logic               w_corner;
  logic               w_last;

  logic signed [51:0] r_resp;
  logic               r_corner, r_out_valid, r_frame_done;
  logic [8:0]         r_out_x, r_out_y, r_next_x, r_next_y;
  logic [31:0]        r_corner_count;

  // Valid bits move through the pipeline; reset empties every stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
    end else begin
      r_v0 <= window_valid;
      r_v1 <= r_v0;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_v4 <= r_v3;
    end
  end

  // Capture the input window and compute the S1 Sobel gradients at the interior centres.
  always_ff @(posedge clk) begin
    r_win <= window_flat;
    for (int i = 32'sd0; i < NC; i++) begin
      r_gx[i] <= sobel_gx(r_win, i / 32'sd4 + 32'sd1, i % 32'sd4 + 32'sd1);
      r_gy[i] <= sobel_gy(r_win, i / 32'sd4 + 32'sd1, i % 32'sd4 + 32'sd1);
    end
  end

  // S2: per-centre structure-tensor products.
  always_ff @(posedge clk) begin
    for (int i = 32'sd0; i < NC; i++) begin
      r_gxx[i] <= sq11(r_gx[i]);
      r_gyy[i] <= sq11(r_gy[i]);
      r_gxy[i] <= mul11(r_gx[i], r_gy[i]);
    end
  end

  // Sum the per-centre products. Widths are chosen so 16 maximal terms cannot overflow.
  always_comb begin
    w_sxx = 24'd0;
    w_syy = 24'd0;
    w_sxy = 25'sd0;
    for (int i = 32'sd0; i < NC; i++) begin
      w_sxx = w_sxx + {4'd0, r_gxx[i]};
      w_syy = w_syy + {4'd0, r_gyy[i]};
      w_sxy = w_sxy + {{4{r_gxy[i][20]}}, r_gxy[i]};
    end
  end

  // S3: register the window sums.
  always_ff @(posedge clk) begin
    r_sxx <= w_sxx;
    r_syy <= w_syy;
    r_sxy <= w_sxy;
  end

  // det and squared trace. Sxy^2 is taken on the magnitude so every product is unsigned.
  always_comb begin
    if (r_sxy[24]) begin
      w_sxy_mag = 24'(-r_sxy);
    end else begin
      w_sxy_mag = r_sxy[23:0];
    end
    w_tr_sum = {1'b0, r_sxx} + {1'b0, r_syy};
    w_det    = ({28'd0, r_sxx} * {28'd0, r_syy}) - ({28'd0, w_sxy_mag} * {28'd0, w_sxy_mag});
    w_tr2    = {27'd0, w_tr_sum} * {27'd0, w_tr_sum};
  end

  // S4: register det and the squared trace.
  always_ff @(posedge clk) begin
    r_det <= $signed(w_det);
    r_tr2 <= w_tr2;
  end

  // Response with k = 1/16, the threshold test, and the end-of-frame position.
  always_comb begin
    w_resp   = r_det - $signed(r_tr2 >> 4);
    w_corner = (w_resp > THRESH);
    w_last   = (r_next_x == X_LAST) && (r_next_y == Y_LAST);
  end

  // S5: register the outputs and advance coordinates. Results hold between valid cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp       <= 52'sd0;
      r_corner     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_x      <= 9'd0;
      r_out_y      <= 9'd0;
      r_next_x     <= 9'd0;
      r_next_y     <= 9'd0;
    end else begin
      r_out_valid <= r_v4;
      if (r_v4) begin
        r_resp       <= w_resp;
        r_corner     <= w_corner;
        r_out_x      <= r_next_x;
        r_out_y      <= r_next_y;
        r_frame_done <= w_last;
        if (r_next_x == X_LAST) begin
          r_next_x <= 9'd0;
          if (r_next_y == Y_LAST) begin
            r_next_y <= 9'd0;
          end else begin
            r_next_y <= r_next_y + 9'd1;
          end
        end else begin
          r_next_x <= r_next_x + 9'd1;
        end
      end else begin
        r_frame_done <= 1'b0;
      end
    end
  end

  // Count corners in the frame. The count restarts on the cycle after frame_done,
  // and that restart still counts a corner that arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_corner_count <= 32'd0;
    end else if (r_frame_done) begin
      r_corner_count <= (r_v4 && w_corner) ? 32'd1 : 32'd0;
    end else if (r_v4 && w_corner && (r_corner_count != CNT_MAX)) begin
      r_corner_count <= r_corner_count + 32'd1;
    end else begin
      r_corner_count <= r_corner_count;
    end
  end

  assign resp         = r_resp;
  assign corner       = r_corner;
  assign out_valid    = r_out_valid;
  assign out_x        = r_out_x;
  assign out_y        = r_out_y;
  assign corner_count = r_corner_count;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_harris_response.sv
`timescale 1ns/1ps
// Testbench for harris_response. It uses a 4x2 frame so that coordinate
// wrap and frame_done happen quickly.
// Test sequences:
//   - single-window table with hand-computed responses
//   - burst of windows with bubbles
//   - reset in the middle of a stream
//   - random windows checked against a behavioural model
module tb_harris_response;

  localparam int     W     = 4;
  localparam int     H     = 2;
  localparam longint TH    = 64'sd1_000_000_000_000;
  localparam longint QUAD  = 64'sd7_492_460_107_500;
  localparam longint EDGE  = -64'sd4_329_728_640_000;
  localparam int     NRAND = 24;

  logic               clk;
  logic               reset;
  logic [287:0]       window_flat;
  logic               window_valid;
  logic signed [51:0] resp;
  logic               corner;
  logic               out_valid;
  logic [8:0]         out_x;
  logic [8:0]         out_y;
  logic [31:0]        corner_count;
  logic               frame_done;

  harris_response #(.IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .window_flat  (window_flat),
    .window_valid (window_valid),
    .resp         (resp),
    .corner       (corner),
    .out_valid    (out_valid),
    .out_x        (out_x),
    .out_y        (out_y),
    .corner_count (corner_count),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Output bookkeeping model: index of the next result, corner count, previous frame_done.
  int     m_nx, m_ny;
  longint m_cc;
  bit     m_prevfd;
  longint prev_resp;

  typedef struct {
    string        name;
    logic [287:0] win;
    longint       exp_resp;
    bit           exp_corner;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_nx = 0; m_ny = 0; m_cc = 0; m_prevfd = 1'b0; prev_resp = 0;
  endtask

  task automatic predict(input bit c, output int ex, output int ey, output bit efd, output longint ecc);
    ex  = m_nx;
    ey  = m_ny;
    efd = (m_nx == W - 1) && (m_ny == H - 1);
    if (m_prevfd) m_cc = 0;
    if (c && m_cc != 64'hFFFF_FFFF) m_cc++;
    ecc = m_cc;
    m_prevfd = efd;
    if (m_nx == W - 1) begin
      m_nx = 0;
      m_ny = (m_ny == H - 1) ? 0 : m_ny + 1;
    end else begin
      m_nx++;
    end
  endtask

  // Compare one valid result against the expected response and the coordinate model.
  task automatic check_result(input longint er, input bit ec, input string tag);
    int ex, ey; bit efd; longint ecc;
    predict(ec, ex, ey, efd, ecc);
    chk({tag, "_resp"},   longint'(resp), er);
    chk({tag, "_corner"}, longint'(corner), longint'(ec));
    chk({tag, "_x"},      longint'(out_x), longint'(ex));
    chk({tag, "_y"},      longint'(out_y), longint'(ey));
    chk({tag, "_fd"},     longint'(frame_done), longint'(efd));
    chk({tag, "_cc"},     longint'(corner_count), ecc);
    prev_resp = er;
  endtask

  function automatic logic [287:0] make_win(input int kind);
    logic [287:0] w;
    logic [7:0]   v;
    w = '0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        case (kind)
          0:       v = 8'd100;
          1:       v = (c >= 3) ? 8'd255 : 8'd0;
          2:       v = (r >= 3 && c >= 3) ? 8'd255 : 8'd0;
          3:       v = (r >= 3) ? 8'd255 : 8'd0;
          4:       v = 8'd0;
          5:       v = (r >= 3 && c >= 3) ? 8'd0 : 8'd255;
          default: v = 8'd255;
        endcase
        w[(r * 6 + c) * 8 +: 8] = v;
      end
    end
    return w;
  endfunction

  function automatic logic [287:0] rand_win();
    logic [287:0] w;
    for (int i = 0; i < 36; i++) w[i * 8 +: 8] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  // Behavioural Harris response computed with plain integers.
  function automatic longint ref_resp(input logic [287:0] w);
    int p[6][6];
    longint sxx, syy, sxy, gx, gy, det, tr2;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        p[r][c] = int'(w[(r * 6 + c) * 8 +: 8]);
    sxx = 0; syy = 0; sxy = 0;
    for (int r = 1; r <= 4; r++) begin
      for (int c = 1; c <= 4; c++) begin
        gx = (p[r-1][c+1] - p[r-1][c-1]) + 2 * (p[r][c+1] - p[r][c-1]) + (p[r+1][c+1] - p[r+1][c-1]);
        gy = (p[r+1][c-1] - p[r-1][c-1]) + 2 * (p[r+1][c] - p[r-1][c]) + (p[r+1][c+1] - p[r-1][c+1]);
        sxx += gx * gx;
        syy += gy * gy;
        sxy += gx * gy;
      end
    end
    det = sxx * syy - sxy * sxy;
    tr2 = (sxx + syy) * (sxx + syy);
    return det - (tr2 >>> 4);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit pat[12];
    bit last_fd, exp_v;
    int nres, nfd, sent, got;
    longint q[$];
    longint er;
    logic [287:0] w;

    tbl[0] = '{"flat100", make_win(0), 64'sd0, 1'b0};
    tbl[1] = '{"vedge",   make_win(1), EDGE,   1'b0};
    tbl[2] = '{"quad",    make_win(2), QUAD,   1'b1};
    tbl[3] = '{"hedge",   make_win(3), EDGE,   1'b0};
    tbl[4] = '{"zero",    make_win(4), 64'sd0, 1'b0};
    tbl[5] = '{"invquad", make_win(5), QUAD,   1'b1};
    tbl[6] = '{"flat255", make_win(6), 64'sd0, 1'b0};

    // Reset state.
    reset = 1'b1; window_valid = 1'b0; window_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_resp",  longint'(resp), 0);
    chk("rst_corner", longint'(corner), 0);
    chk("rst_fd",    longint'(frame_done), 0);
    chk("rst_x",     longint'(out_x), 0);
    chk("rst_y",     longint'(out_y), 0);
    chk("rst_cc",    longint'(corner_count), 0);
    reset = 1'b0;
    model_reset();

    // Single windows from the table: check latency, hold behaviour and the result.
    for (int i = 0; i < 7; i++) begin
      window_flat = tbl[i].win;
      window_valid = 1'b1;
      @(posedge clk);
      #1;
      window_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk({tbl[i].name, "_early"}, longint'(out_valid), 0);
      chk({tbl[i].name, "_hold"},  longint'(resp), prev_resp);
      @(posedge clk);
      #1;
      chk({tbl[i].name, "_valid"}, longint'(out_valid), 1);
      check_result(tbl[i].exp_resp, tbl[i].exp_corner, tbl[i].name);
    end

    // Burst of quadrant windows with bubbles. This covers one full 4x2 frame.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    pat = '{1, 1, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0};
    last_fd = 1'b0; nres = 0; nfd = 0;
    for (int t = 0; t < 20; t++) begin
      window_flat = make_win(2);
      window_valid = (t < 12) ? pat[t] : 1'b0;
      @(posedge clk);
      #1;
      exp_v = (t >= 5 && t - 5 < 12) ? pat[t - 5] : 1'b0;
      chk("bubble_valid", longint'(out_valid), longint'(exp_v));
      if (out_valid) begin
        check_result(QUAD, 1'b1, "burst");
        nres++;
        if (frame_done) nfd++;
      end else if (last_fd) begin
        chk("cc_clear", longint'(corner_count), 0);
        chk("fd_pulse", longint'(frame_done), 0);
      end
      last_fd = out_valid & frame_done;
    end
    window_valid = 1'b0;
    chk("burst_results", nres, 8);
    chk("burst_frames", nfd, 1);

    // Three windows in flight, then reset lands as the first one would emerge.
    for (int k = 0; k < 3; k++) begin
      window_flat = make_win(2);
      window_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    window_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_resp",  longint'(resp), 0);
    chk("mid_rst_corner", longint'(corner), 0);
    chk("mid_rst_x",     longint'(out_x), 0);
    chk("mid_rst_y",     longint'(out_y), 0);
    chk("mid_rst_cc",    longint'(corner_count), 0);
    chk("mid_rst_fd",    longint'(frame_done), 0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk("flushed_valid", longint'(out_valid), 0);
    end
    model_reset();

    // Random windows mixed with quadrant corners, compared against the model.
    sent = 0; got = 0; nfd = 0;
    for (int cyc = 0; cyc < 600 && got < NRAND; cyc++) begin
      if (sent < NRAND && $urandom_range(0, 3) != 0) begin
        w = ($urandom_range(0, 3) == 0) ? make_win(2) : rand_win();
        window_flat = w;
        window_valid = 1'b1;
        q.push_back(ref_resp(w));
        sent++;
      end else begin
        window_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected", 1, 0);
        end else begin
          er = q.pop_front();
          check_result(er, er > TH, "rnd");
        end
        got++;
        if (frame_done) nfd++;
      end
    end
    window_valid = 1'b0;
    chk("rnd_count", got, NRAND);
    chk("rnd_frames", nfd, NRAND / (W * H));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
